uart_rx_buffered: RTL

Serial receiver for the SoC's UART line: the receiving end of the 8N1 stream the SoC already transmits. It synchronises the `uart_rx` pin, oversamples with a counter, deframes bytes LSB-first, and queues them in a small FIFO behind a valid/ready handshake. It sits inside `SoC` between the top-level `uart_rx` pin and the memory-mapped UART registers, running in the `soc_clk` domain.

---
 rtl/uart_rx_buffered_pkg.sv | 21 ++
 rtl/uart_rx_buffered_if.sv | 12 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_rx_buffered.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/uart_rx_buffered_pkg.sv
// Shared 8N1 UART definitions: frame shape, receiver FSM states and baud helper.
package uart_rx_buffered_pkg;

  localparam int unsigned DataBits = 8;
  localparam int unsigned StopBits = 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  // Clock cycles per bit; shared with the transmitter so both ends agree.
  function automatic int unsigned bit_ticks(input int unsigned clk_freq,
                                            input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// Byte stream handshake between the receiver FIFO and its consumer.
interface uart_rx_buffered_if;
  import uart_rx_buffered_pkg::*;

  logic [DataBits-1:0] data;
  logic                valid;
  logic                ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is taken only with a pop.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push;
  logic                  do_pop;

  // Status, handshake qualification and head-of-queue read.
  always_comb begin
    empty    = (count_q == '0);
    // count never exceeds Depth, so its MSB alone marks full
    full     = count_q[DEPTH_LOG2];
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    pop_data = empty ? '0 : mem_q[rd_ptr_q];
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage array; contents need no reset since empty masks the output.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver: input synchroniser, oversampling deframer FSM and byte FIFO.
module uart_rx_buffered
  import uart_rx_buffered_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 27_000_000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 clr_err,
  output logic                 overrun,
  output logic                 frame_err,
  uart_rx_buffered_if.master   bus
);

  localparam int unsigned BitTicks = bit_ticks(CLK_FREQ, BAUD_RATE);
  localparam int unsigned Half     = BitTicks / 2;
  localparam int unsigned CntW     = $clog2(BitTicks);
  localparam int unsigned IdxW     = $clog2(DataBits);

  localparam logic [CntW-1:0] BitLoad  = CntW'(BitTicks - 1);
  localparam logic [CntW-1:0] HalfLoad = CntW'(Half - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(DataBits - 1);

  logic                sync1_q, sync2_q;
  rx_state_e           state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [DataBits-1:0] shreg_q, shreg_d;
  logic                overrun_q, overrun_d;
  logic                frame_err_q, frame_err_d;
  logic                tick;
  logic                push;
  logic                ferr_set;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;

  assign tick      = (cnt_q == '0);
  assign pop       = bus.valid && bus.ready;
  assign bus.valid = !fifo_empty;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

  // Deframer next-state: all sampling decisions are taken when the counter reads zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = tick ? cnt_q : cnt_q - 1'b1;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!sync2_q) begin
          cnt_d   = HalfLoad;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          if (!sync2_q) begin
            cnt_d   = BitLoad;
            idx_d   = '0;
            state_d = StData;
          end else begin
            state_d = StIdle;  // start bit did not hold: glitch
          end
        end
      end
      StData: begin
        if (tick) begin
          shreg_d[idx_q] = sync2_q;
          cnt_d          = BitLoad;
          if (idx_q == LastIdx) state_d = StStop;
          else                  idx_d   = idx_q + 1'b1;
        end
      end
      StStop: begin
        if (tick) begin
          if (sync2_q) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_set = 1'b1;
            state_d  = StBreak;
          end
        end
      end
      StBreak: begin
        // hold off until the line returns high so a break is not seen as a start
        if (sync2_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky error flags; a new event wins over a clear in the same cycle.
  always_comb begin
    overrun_d   = (push && fifo_full && !pop) || (overrun_q && !clr_err);
    frame_err_d = ferr_set || (frame_err_q && !clr_err);
  end

  // Synchroniser, FSM and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  sync_fifo #(
    .WIDTH      (DataBits),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg_d),
    .full      (fifo_full),
    .pop       (pop),
    .pop_data  (bus.data),
    .empty     (fifo_empty)
  );

endmodule
